// File: rtl/e_mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op codes,
// latency constants and FSM state encoding.
package e_mdu_pkg;

  // Multiply/divide operation codes carried on in_mdop
  typedef enum logic [3:0] {
    MDU_NONE = 4'd0,
    MULT     = 4'd1,
    MULTU    = 4'd2,
    DIV      = 4'd3,
    DIVU     = 4'd4,
    MTHI     = 4'd5,
    MTLO     = 4'd6,
    MADD     = 4'd7,
    MADDU    = 4'd8,
    MSUB     = 4'd9,
    MSUBU    = 4'd10
  } mdop_t;

  // Busy-cycle counts loaded into the down-counter at issue
  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit holding the HI/LO registers.
// Multiplies take 5 busy cycles, divides 10; results land on HI/LO only at
// the completing edge. Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU
// (multiply-accumulate into {HI,LO}); otherwise those codes act as MDU_NONE.
module e_mdu
  import e_mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_start,
  input  logic [3:0]  in_mdop,
  input  logic [31:0] in_rs,
  input  logic [31:0] in_rt,
  output logic        out_busy,
  output logic [31:0] out_hi,
  output logic [31:0] out_lo
);

  state_t      state;
  logic [3:0]  cnt;
  mdop_t       op_q;
  logic [31:0] rs_q;
  logic [31:0] rt_q;

  logic [3:0]  start_lat;
  logic        mul_signed;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  // Decode the issuing op into its latency; zero means "not a long op"
  always_comb begin
    start_lat = 4'd0;
    case (in_mdop)
      MULT, MULTU: start_lat = MULT_CYCLES;
      DIV, DIVU:   start_lat = DIV_CYCLES;
`ifdef MDU_MADD_EN
      MADD, MADDU, MSUB, MSUBU: start_lat = MULT_CYCLES;
`endif
      default:     start_lat = 4'd0;
    endcase
  end

  // Result of the in-flight op; defaults to current HI/LO so ops that must
  // not write (divide by zero) simply rewrite the old values
  always_comb begin
    mul_signed = (op_q == MULT) || (op_q == MADD) || (op_q == MSUB);
    a_ext  = {{32{mul_signed & rs_q[31]}}, rs_q};
    b_ext  = {{32{mul_signed & rt_q[31]}}, rt_q};
    prod   = a_ext * b_ext;
    res_hi = out_hi;
    res_lo = out_lo;
    case (op_q)
      MULT, MULTU: {res_hi, res_lo} = prod;
      DIV: begin
        if (rt_q != 32'd0) begin
          if (rs_q == 32'h8000_0000 && rt_q == 32'hFFFF_FFFF) begin
            res_lo = 32'h8000_0000;
            res_hi = 32'd0;
          end else begin
            res_lo = $signed(rs_q) / $signed(rt_q);
            res_hi = $signed(rs_q) % $signed(rt_q);
          end
        end
      end
      DIVU: begin
        if (rt_q != 32'd0) begin
          res_lo = rs_q / rt_q;
          res_hi = rs_q % rt_q;
        end
      end
`ifdef MDU_MADD_EN
      MADD, MADDU: {res_hi, res_lo} = {out_hi, out_lo} + prod;
      MSUB, MSUBU: {res_hi, res_lo} = {out_hi, out_lo} - prod;
`endif
      default: ;
    endcase
  end

  // IDLE/BUSY control, operand capture, countdown and HI/LO update
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      out_busy <= 1'b0;
      out_hi   <= 32'd0;
      out_lo   <= 32'd0;
      op_q     <= MDU_NONE;
      rs_q     <= 32'd0;
      rt_q     <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_start) begin
            if (start_lat != 4'd0) begin
              op_q     <= mdop_t'(in_mdop);
              rs_q     <= in_rs;
              rt_q     <= in_rt;
              cnt      <= start_lat;
              state    <= BUSY;
              out_busy <= 1'b1;
            end else if (in_mdop == MTHI) begin
              out_hi <= in_rs;
            end else if (in_mdop == MTLO) begin
              out_lo <= in_rs;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) begin
            cnt      <= 4'd0;
            state    <= IDLE;
            out_busy <= 1'b0;
            out_hi   <= res_hi;
            out_lo   <= res_lo;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
